// File: rtl/spsram_adapter_pkg.sv
// Shared types and default geometry for the 8192x32 single-port SRAM request adapter.
// No logic; constants only.
// Not applicable.
package spsram_adapter_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int WORDS      = 1 << ADDR_WIDTH;

    // S_INIT zero-fills the array; S_RUN serves requests.
    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/spsram_rsp_fifo.sv
// Small synchronous FIFO holding read responses in order.
// Pushed data is visible at the head the cycle after the push.
// No internal backpressure: the caller must never push while full or pop while empty.
module spsram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/spsram_8192x32_req_adapter.sv
// Drives the 8192x32 SRAM pins from a read/write request stream; zero-fills the array after reset.
// Read accepted at cycle t: Q captured at t+1, rsp_valid at t+2 (later if earlier responses are queued).
// req_ready drops once RSP_DEPTH reads are outstanding; a pop frees credit combinationally the same cycle.
module spsram_8192x32_req_adapter #(
    parameter int ADDR_WIDTH = spsram_adapter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = spsram_adapter_pkg::DATA_WIDTH,
    parameter int RSP_DEPTH  = 2,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic                    CEN,
    output logic                    GWEN,
    output logic [DATA_WIDTH-1:0]   WEN,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);

    import spsram_adapter_pkg::*;

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
    logic                    inflight_q, inflight_d;

    logic                    accept;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    unused_fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [CNT_W:0]          occ;

    // The read issued last cycle has its data on Q now; capture it unconditionally.
    assign fifo_push = inflight_q;
    assign rsp_valid = !fifo_empty && !RST;
    assign rsp_rdata = fifo_head;
    assign fifo_pop  = rsp_valid && rsp_ready;
    assign init_done = (state_q == S_RUN);

    // Credits consumed by reads not yet handed downstream, net of this cycle's pop.
    assign occ = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(fifo_pop);

    // Pin drive, request acceptance and next-state; pins stay idle while reset is held.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        inflight_d  = 1'b0;
        req_ready   = 1'b0;
        accept      = 1'b0;
        A           = req_addr;
        CEN         = 1'b1;
        GWEN        = 1'b1;
        WEN         = '1;
        D           = req_wdata;
        if (!RST) begin
            case (state_q)
                S_INIT: begin
                    A           = init_addr_q;
                    CEN         = 1'b0;
                    GWEN        = 1'b0;
                    WEN         = '0;
                    D           = '0;
                    init_addr_d = init_addr_q + ADDR_WIDTH'(1);
                    if (init_addr_q == '1) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    req_ready  = (occ < (CNT_W+1)'(RSP_DEPTH));
                    accept     = req_valid && req_ready;
                    CEN        = ~accept;
                    GWEN       = ~req_write;
                    for (int i = 0; i < BE_W; i++) begin
                        WEN[8*i +: 8] = {8{~req_be[i]}};
                    end
                    inflight_d = accept && !req_write;
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    // State registers; reset restarts the zero-fill (or goes straight to RUN) and drops any in-flight read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= INIT_EN ? S_INIT : S_RUN;
            init_addr_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            inflight_q  <= inflight_d;
        end
    end

    spsram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (fifo_push),
        .push_dat (Q),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (unused_fifo_full)
    );

endmodule

// File: tb/tb_spsram_8192x32_req_adapter.sv
// Bench for the SRAM request adapter: SRAM macro model, behavioural reference model, random traffic.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Response back-pressure exercised with rsp_ready held low, pulsed and randomised.
module tb_spsram_8192x32_req_adapter;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 2;
    localparam int WORDS = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    always #5 CLK = ~CLK;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] A;
    logic          CEN, GWEN;
    logic [DW-1:0] WEN, D, Q;

    logic          req_ready0, rsp_valid0, init_done0, CEN0, GWEN0;
    logic [DW-1:0] rsp_rdata0, WEN0, D0, Q0;
    logic [AW-1:0] A0;
    logic          req_valid0, req_write0, rsp_ready0;
    logic [AW-1:0] req_addr0;
    logic [DW-1:0] req_wdata0;
    logic [BW-1:0] req_be0;

    assign Q0 = '0;

    spsram_8192x32_req_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH), .INIT_EN(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
    );

    spsram_8192x32_req_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH), .INIT_EN(1'b0)
    ) dut0 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
        .init_done(init_done0),
        .A(A0), .CEN(CEN0), .GWEN(GWEN0), .WEN(WEN0), .D(D0), .Q(Q0)
    );

    // SRAM macro model: never-written words read back as garbage so the zero-fill matters.
    logic [DW-1:0] sram    [WORDS];
    bit            written [WORDS];
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                sram[A]    <= ((written[A] ? sram[A] : (32'hBAD0_0000 ^ 32'(A))) & WEN) | (D & ~WEN);
                written[A] <= 1'b1;
            end else begin
                Q <= written[A] ? sram[A] : (32'hBAD0_0000 ^ 32'(A));
            end
        end
    end

    // Reference model state
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] q_dat [$];
    int            q_rdy [$];
    bit            m_run;
    int            m_init;
    int            init_wr_cnt;

    // Snapshots taken at the sampling edge for the stimulus code to inspect.
    int            s_cyc;
    logic          s_req_ready, s_rsp_valid, s_init_done, s_CEN, s_init_done0, s_req_ready0;
    logic [DW-1:0] s_rsp_rdata;
    logic [AW-1:0] s_A;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] wen_of(input logic [BW-1:0] be);
        logic [DW-1:0] w;
        for (int i = 0; i < BW; i++) w[8*i +: 8] = be[i] ? 8'h00 : 8'hFF;
        return w;
    endfunction

    task automatic model_check();
        bit ev, pop, er, acc;
        s_cyc = cyc; s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_rdata = rsp_rdata;
        s_init_done = init_done; s_A = A; s_CEN = CEN;
        s_init_done0 = init_done0; s_req_ready0 = req_ready0;
        if (RST) begin
            chk("rst_cen", 32'(CEN), 32'd1);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            q_dat.delete(); q_rdy.delete();
            m_run = 1'b0; m_init = 0; init_wr_cnt = 0;
        end else begin
            chk("nofill_init_done", 32'(init_done0), 32'd1);
            chk("nofill_req_ready", 32'(req_ready0), 32'd1);
            chk("nofill_cen", 32'(CEN0), 32'd1);
            chk("fifo_overflow", 32'(dut.u_rsp_fifo.push & dut.u_rsp_fifo.full), 32'd0);
            if (!m_run) begin
                chk("init_done_low", 32'(init_done), 32'd0);
                chk("init_req_ready", 32'(req_ready), 32'd0);
                chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("init_cen_gwen", {30'd0, CEN, GWEN}, 32'd0);
                chk("init_wen", WEN, 32'd0);
                chk("init_d", D, 32'd0);
                chk("init_a", 32'(A), 32'(m_init));
                if (!CEN && !GWEN && WEN == '0) init_wr_cnt++;
                ref_mem[m_init] = '0;
                m_init++;
                if (m_init == WORDS) m_run = 1'b1;
            end else begin
                ev = (q_dat.size() > 0) && (q_rdy[0] <= cyc);
                chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                if (ev) chk("rsp_rdata", rsp_rdata, q_dat[0]);
                pop = ev && rsp_ready;
                er  = (q_dat.size() - int'(pop)) < DEPTH;
                chk("run_init_done", 32'(init_done), 32'd1);
                chk("req_ready", 32'(req_ready), 32'(er));
                acc = req_valid && er;
                chk("cen", 32'(CEN), 32'(!acc));
                if (pop) begin
                    void'(q_dat.pop_front());
                    void'(q_rdy.pop_front());
                end
                if (acc) begin
                    chk("acc_a", 32'(A), 32'(req_addr));
                    chk("acc_gwen", 32'(GWEN), 32'(!req_write));
                    if (req_write) begin
                        chk("acc_d", D, req_wdata);
                        chk("acc_wen", WEN, wen_of(req_be));
                        for (int i = 0; i < BW; i++)
                            if (req_be[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                    end else begin
                        q_dat.push_back(ref_mem[req_addr]);
                        q_rdy.push_back(cyc + 2);
                    end
                end
            end
        end
    endtask

    // One clock cycle: sample and check at the falling edge, optionally raise reset, then advance.
    task automatic tick(input bit raise_rst = 1'b0);
        @(negedge CLK);
        model_check();
        if (raise_rst) begin
            #1 RST = 1'b1;
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic wait_init(input string nm);
        int t0, t_done;
        t0 = cyc; t_done = -1;
        for (int i = 0; i < 9000 && t_done < 0; i++) begin
            tick();
            if (i == 0) begin
                chk({nm, "_first_a"}, 32'(s_A), 32'd0);
                chk({nm, "_first_cen"}, 32'(s_CEN), 32'd0);
                chk({nm, "_first_rsp_valid"}, 32'(s_rsp_valid), 32'd0);
            end
            if (s_init_done) t_done = s_cyc;
        end
        if (t_done < 0) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_cycles"}, 32'(t_done - t0), 32'd8192);
            chk({nm, "_writes"}, 32'(init_wr_cnt), 32'd8192);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
        bit done;
        done = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data; req_be = be;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = s_req_ready;
        end
        req_valid = 1'b0;
        if (!done) chk("write_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_expect(input string nm, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        int t_acc;
        bit got;
        t_acc = -1; got = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        for (int i = 0; i < 20 && t_acc < 0; i++) begin
            tick();
            if (s_req_ready) t_acc = s_cyc;
        end
        req_valid = 1'b0;
        if (t_acc < 0) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                if (s_rsp_valid) begin
                    got = 1'b1;
                    chk({nm, "_data"}, s_rsp_rdata, exp);
                    chk({nm, "_latency"}, 32'(s_cyc - t_acc), 32'd2);
                end
            end
            if (!got) chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic drain();
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 50 && q_dat.size() > 0; i++) tick();
        chk("drain_empty", 32'(q_dat.size()), 32'd0);
    endtask

    initial begin
        int n;
        RST = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0; rsp_ready0 = 1'b1;
        repeat (3) tick();
        RST = 1'b0;

        // Zero-fill after reset; the INIT_EN=0 instance must be ready at once.
        wait_init("fill");
        read_expect("rd_1abc", 13'h1ABC, 32'h0000_0000);

        // Byte-masked overwrite.
        do_write(13'h0010, 32'hDEAD_BEEF, 4'hF);
        do_write(13'h0010, 32'h1122_3344, 4'h5);
        read_expect("rd_merge", 13'h0010, 32'hDE22_BE44);

        // 100 back-to-back reads with the consumer always ready.
        n = 0;
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            req_addr = AW'($urandom_range(0, 63));
            tick();
            if (s_req_ready) n++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd100);
        drain();

        // Back-pressure: two reads fill the credits, one pop frees one the same cycle.
        n = 0;
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'($urandom_range(0, 63));
            tick();
            if (s_req_ready) n++;
        end
        chk("bp_accepts", 32'(n), 32'd2);
        chk("bp_ready_low", 32'(s_req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_ready_on_pop", 32'(s_req_ready), 32'd1);
        chk("bp_valid_on_pop", 32'(s_rsp_valid), 32'd1);
        rsp_ready = 1'b0;
        tick();
        chk("bp_ready_relow", 32'(s_req_ready), 32'd0);
        drain();

        // Random mixed traffic over a small address window.
        for (int i = 0; i < 2000; i++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 31));
            req_wdata = $urandom;
            req_be    = BW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain();

        // Reset with one read in flight and one response buffered.
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
        req_addr = 13'h0005;
        tick();
        chk("mid_acc1", 32'(s_req_ready), 32'd1);
        req_addr = 13'h0006;
        tick();
        chk("mid_acc2", 32'(s_req_ready), 32'd1);
        req_valid = 1'b0;
        tick(1'b1);
        chk("mid_buffered", 32'(s_rsp_valid), 32'd1);
        chk("mid_credit_full", 32'(s_req_ready), 32'd0);
        tick();
        RST = 1'b0;
        rsp_ready = 1'b1;
        wait_init("refill");

        // Short random run after the refill.
        for (int i = 0; i < 200; i++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_be    = BW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 5);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
